// File: rtl/binario_a_bcd_pkg.sv
// rtl/binario_a_bcd_pkg.sv - shared constants and types for the binary to BCD converter
package binario_a_bcd_pkg;

    localparam int BCD_DIGIT_W    = 4;
    localparam int ADD3_THRESHOLD = 5;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    // Decimal range of a given number of digits, used for the elaboration-time width check.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - one double-dabble digit correction (add 3 when the digit is 5 or more)
module bcd_add3
    import binario_a_bcd_pkg::*;
(
    input  bcd_digit_t digit_in,
    output bcd_digit_t digit_out
);

    assign digit_out = (digit_in >= bcd_digit_t'(ADD3_THRESHOLD))
                     ? digit_in + bcd_digit_t'(3)
                     : digit_in;

endmodule

// File: rtl/binario_a_bcd.sv
// rtl/binario_a_bcd.sv - combinational double-dabble converter with a registered output
module binario_a_bcd
    import binario_a_bcd_pkg::*;
#(
    parameter int BIN_W      = 4,
    parameter int BCD_DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [BIN_W-1:0]          binary_input,
    output logic [4*BCD_DIGITS-1:0]   bcd_output,
    output logic                      out_valid
);

    localparam int W = BCD_DIGIT_W * BCD_DIGITS;

    if (pow10(BCD_DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_params
        $error("binario_a_bcd: BCD_DIGITS too small for BIN_W");
    end

    logic [W-1:0] stage_bcd [0:BIN_W];

    assign stage_bcd[0] = '0;

    // Each stage corrects every digit, then shifts in the next input bit, MSB first.
    for (genvar s = 0; s < BIN_W; s++) begin : g_stage
        logic [W-1:0] corr;
        logic         unused_msb;

        for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_digit
            bcd_add3 u_add3 (
                .digit_in  (stage_bcd[s][d*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_out (corr[d*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end

        // The shifted-out bit is always zero given the digit-count check above.
        assign unused_msb       = corr[W-1];
        assign stage_bcd[s+1]   = {corr[W-2:0], binary_input[BIN_W-1-s]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_output <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                bcd_output <= stage_bcd[BIN_W];
            end
        end
    end

endmodule

// File: tb/tb_binario_a_bcd.sv
// tb/tb_binario_a_bcd.sv - self-checking bench for binario_a_bcd (default and 8-bit configurations)
module tb_binario_a_bcd;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  binary_input;
    logic [7:0]  bcd_output;
    logic        out_valid;

    logic        in_valid8;
    logic [7:0]  binary_input8;
    logic [11:0] bcd_output8;
    logic        out_valid8;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] exp8_q [$];
    logic [31:0] last_bcd;
    logic [31:0] last_bcd8;

    binario_a_bcd dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .binary_input (binary_input),
        .bcd_output   (bcd_output),
        .out_valid    (out_valid)
    );

    binario_a_bcd #(.BIN_W(8), .BCD_DIGITS(3)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid8),
        .binary_input (binary_input8),
        .bcd_output   (bcd_output8),
        .out_valid    (out_valid8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] bcd_model(input int v, input int digits);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < digits; k++) begin
            r[k*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_digits(input string tag, input logic [31:0] value, input int digits);
        logic [3:0] nib;
        for (int k = 0; k < digits; k++) begin
            nib = value[k*4 +: 4];
            check(tag, {31'd0, (nib <= 4'd9)}, 32'd1);
        end
    endtask

    // One cycle on the default instance; expected results are queued and popped as out_valid appears.
    task automatic step(input string tag, input int v, input logic valid);
        logic [31:0] e;
        @(negedge clk);
        binary_input = 4'(v);
        in_valid     = valid;
        if (valid) exp_q.push_back(bcd_model(v, 2));
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_bcd"}, {24'd0, bcd_output}, e);
            check_digits({tag, "_digit"}, {24'd0, bcd_output}, 2);
            last_bcd = e;
        end else begin
            check({tag, "_novalid"}, {31'd0, out_valid}, 32'd0);
            check({tag, "_hold"}, {24'd0, bcd_output}, last_bcd);
        end
    endtask

    task automatic step8(input string tag, input int v, input logic valid);
        logic [31:0] e;
        @(negedge clk);
        binary_input8 = 8'(v);
        in_valid8     = valid;
        if (valid) exp8_q.push_back(bcd_model(v, 3));
        @(posedge clk);
        #1;
        if (exp8_q.size() > 0) begin
            e = exp8_q.pop_front();
            check({tag, "_valid"}, {31'd0, out_valid8}, 32'd1);
            check({tag, "_bcd"}, {20'd0, bcd_output8}, e);
            check_digits({tag, "_digit"}, {20'd0, bcd_output8}, 3);
            last_bcd8 = e;
        end else begin
            check({tag, "_novalid"}, {31'd0, out_valid8}, 32'd0);
            check({tag, "_hold"}, {20'd0, bcd_output8}, last_bcd8);
        end
    endtask

    initial begin
        int sweep [10] = '{0, 1, 3, 4, 5, 7, 9, 10, 13, 15};

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        binary_input  = '0;
        in_valid8     = 1'b0;
        binary_input8 = '0;
        last_bcd      = '0;
        last_bcd8     = '0;

        #12;
        check("reset_bcd", {24'd0, bcd_output}, 32'h0);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_bcd8", {20'd0, bcd_output8}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known values from the default-configuration table.
        check("tbl_15", bcd_model(15, 2), 32'h15);
        foreach (sweep[i]) step("sweep", sweep[i], 1'b1);
        step("idle", 0, 1'b0);

        // Hold: a non-qualified input must not disturb the last result.
        step("hold_load", 13, 1'b1);
        step("hold", 7, 1'b0);
        step("hold2", 7, 1'b0);

        // Exhaustive back-to-back.
        for (int v = 0; v < 16; v++) step("exh", v, 1'b1);
        step("exh_idle", 0, 1'b0);

        // Reset asserted mid-cycle right after a capture, with in_valid still high.
        step("rst_cap", 9, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_bcd", {24'd0, bcd_output}, 32'h0);
        check("rst_async_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_bcd", {24'd0, bcd_output}, 32'h0);
        check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("rst_rel_bcd", {24'd0, bcd_output}, 32'h0);
        check("rst_rel_valid", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        last_bcd = '0;
        step("post_rst_idle", 0, 1'b0);
        step("post_rst", 10, 1'b1);

        // Wider configuration.
        step8("w8_255", 255, 1'b1);
        step8("w8_100", 100, 1'b1);
        step8("w8_099", 99, 1'b1);
        step8("w8_hold", 3, 1'b0);
        step8("w8_000", 0, 1'b1);
        check("w8_queue_empty", exp8_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/binario_a_bcd.md
BINARIO_A_BCD -- requirements
Module: binario_a_bcd

Interface
REQ-001 Parameter BIN_W, default 4: width of the unsigned binary input.
REQ-002 Parameter BCD_DIGITS, default 2: number of packed BCD digits in the output; SHALL satisfy 10**BCD_DIGITS > 2**BIN_W - 1, checked at elaboration.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  qualifies binary_input in the current cycle.
REQ-007 binary_input  input  BIN_W  unsigned binary value to convert.
REQ-008 bcd_output  output  4*BCD_DIGITS  packed BCD, least significant digit in bits [3:0]; default 8 bits.
REQ-009 out_valid  output  1  high for one cycle when bcd_output holds a new conversion.

Function
REQ-010 The block SHALL compute the decimal representation of binary_input: digit k = (binary_input / 10**k) mod 10, each digit 4 bits, packed from LSB.
REQ-011 The conversion SHALL be the shift-and-add-3 (double-dabble) method: BIN_W iterations, each adding 3 to any digit >= 5, then shifting left one bit with the next input MSB.
REQ-012 The conversion datapath SHALL be combinational, with its result captured in an output register.
REQ-013 Latency SHALL be exactly 1 cycle: a value sampled with in_valid=1 at edge N appears on bcd_output, with out_valid=1, after edge N.
REQ-014 When in_valid=0 at an edge, bcd_output SHALL hold its previous value and out_valid SHALL be 0.
REQ-015 Back-to-back in_valid cycles SHALL be accepted every cycle; there is no backpressure.
REQ-016 Every digit of bcd_output SHALL always be in 0..9; no code 0xA..0xF ever appears.
REQ-017 Unused upper digits SHALL be 0 (e.g. the tens digit for inputs 0..9).
REQ-018 For the default configuration: 0->0x00, 9->0x09, 10->0x10, 13->0x13, 15->0x15 (maximum input).

Reset
REQ-019 While rst_n=0, bcd_output SHALL be 0 and out_valid SHALL be 0, immediately and independent of clk.
REQ-020 Deassertion of rst_n SHALL be synchronized to clk; the first capture occurs at the first rising edge with rst_n=1 and in_valid=1.
REQ-021 If reset asserts in the cycle after a capture, out_valid SHALL drop to 0 at once, and that result SHALL be discarded.

Structure
REQ-022 Package binario_a_bcd_pkg SHALL hold the BCD digit width constant (4), the add-3 threshold constant (5), and a digit typedef (logic [3:0]).
REQ-023 A sub-module bcd_add3 SHALL implement one digit correction: output = in + 3 if in >= 5, else in.
REQ-024 The top SHALL instantiate bcd_add3 in a generate array of BIN_W stages x BCD_DIGITS digits, followed by the output register.

Verification
REQ-025 Reset: assert rst_n=0 mid-run with in_valid=1 -> bcd_output=0x00 and out_valid=0 immediately, and both hold until after release.
REQ-026 Sweep: apply binary_input 0,1,3,4,5,7,9,10,13,15, each with in_valid=1 for one cycle -> one cycle later bcd_output = 0x00,0x01,0x03,0x04,0x05,0x07,0x09,0x10,0x13,0x15 respectively, with out_valid=1.
REQ-027 Hold: binary_input=13 with in_valid=1, then binary_input=7 with in_valid=0 -> bcd_output stays 0x13, out_valid=0.
REQ-028 Exhaustive: drive all 16 inputs back-to-back -> every output matches the tens digit (v/10) and ones digit (v%10), and no digit exceeds 9.
REQ-029 Parameters: BIN_W=8 and BCD_DIGITS=3 with input 255 -> bcd_output=0x255; input 100 -> 0x100.
